// File: rtl/dbus_sram_resp_pkg.sv
// Shared data-bus types for the core-to-SRAM response path.
// Also holds the word geometry used by the SRAM model.
package dbus_sram_resp_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STRB_W  = WORD_W / 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic              valid;
        logic [31:0]       addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [WORD_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [WORD_W-1:0] data;
    } dbus_resp_t;

    // Halfwords need even addresses and words need 4-byte alignment.
    function automatic logic is_misaligned(input msize_t size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MSIZE2:  mis = addr_lo[0];
            MSIZE4:  mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dbus_sram_resp_sram_array.sv
// Byte-strobed word array: one combinational read port, one strobed write port.
// A read in the same cycle as a write to the same word returns the old contents.
module sram_array
    import dbus_sram_resp_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/dbus_sram_resp.sv
// Single-outstanding data-bus SRAM responder with fixed response latency.
// Misaligned accesses complete the handshake without side effects and raise a sticky err.
module dbus_sram_resp
    import dbus_sram_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    msize_t            size_q, size_d;
    logic [STRB_W-1:0] strobe_q, strobe_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              mis_c;
    logic              we_c;
    logic [WORD_W-1:0] rdata_c;
    logic              unused_addr_c;

    assign mis_c         = is_misaligned(size_q, addr_q[1:0]);
    assign unused_addr_c = ^addr_q[31:IDX_W+2];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        data_d   = data_q;
        err_d    = err_q;
        we_c     = 1'b0;
        dresp    = '0;

        case (state_q)
            IDLE: begin
                dresp.addr_ok = dreq.valid;
                if (dreq.valid) begin
                    addr_d   = dreq.addr;
                    size_d   = dreq.size;
                    strobe_d = dreq.strobe;
                    data_d   = dreq.data;
                    cnt_d    = CNT_W'(LATENCY);
                    state_d  = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                dresp.data_ok = 1'b1;
                if (!mis_c && strobe_q == '0) begin
                    dresp.data = rdata_c;
                end
                we_c    = !mis_c && (strobe_q != '0);
                err_d   = err_q | mis_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle aborts any pending response or write.
        if (!resetn) begin
            dresp = '0;
            we_c  = 1'b0;
        end
    end

    assign err = err_q | (resetn && (state_q == RESP) && mis_c);

    sram_array #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk     (clk),
        .we      (we_c),
        .waddr   (addr_q[IDX_W+1:2]),
        .wstrb   (strobe_q),
        .wdata   (data_q),
        .raddr   (addr_q[IDX_W+1:2]),
        .rdata_c (rdata_c)
    );

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Bench for dbus_sram_resp: directed scenarios plus random traffic against a
// behavioural memory model; a second LATENCY=0 instance covers back-to-back reads.
module tb_dbus_sram_resp;
    import dbus_sram_resp_pkg::*;

    localparam int unsigned LAT    = 2;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned DEPTH2 = 16;

    logic       clk = 1'b0;
    logic       resetn;
    dbus_req_t  dreq, dreq2;
    dbus_resp_t dresp, dresp2;
    logic       err, err2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [DEPTH];
    logic        err_m;

    always #5 clk = ~clk;

    dbus_sram_resp #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .dreq(dreq), .dresp(dresp), .err(err)
    );

    dbus_sram_resp #(.LATENCY(0), .DEPTH(DEPTH2)) dut_l0 (
        .clk(clk), .resetn(resetn), .dreq(dreq2), .dresp(dresp2), .err(err2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit misaligned_m(input msize_t s, input logic [31:0] a);
        return (s == MSIZE2 && a[0]) || (s == MSIZE4 && a[1:0] != 2'b00);
    endfunction

    task automatic drive_garbage();
        dreq.valid  = 1'b1;
        dreq.addr   = $urandom;
        dreq.size   = msize_t'($urandom_range(0, 2));
        dreq.strobe = 4'($urandom);
        dreq.data   = $urandom;
    endtask

    // Issue one request from an IDLE cycle and follow it to completion.
    task automatic txn(input logic [31:0] a, input msize_t s, input logic [3:0] st,
                       input logic [31:0] d, output logic [31:0] got);
        logic [31:0] exp_data;
        int          idx;
        bit          mis;
        int          lat;
        dreq = '{valid: 1'b1, addr: a, size: s, strobe: st, data: d};
        #1;
        check_eq("addr_ok_accept", 32'(dresp.addr_ok), 32'd1);
        idx = int'((a >> 2) % DEPTH);
        mis = misaligned_m(s, a);
        exp_data = (!mis && st == 4'd0) ? mem_m[idx] : 32'd0;
        lat = -1;
        got = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            step();
            drive_garbage();
            #1;
            check_eq("addr_ok_busy", 32'(dresp.addr_ok), 32'd0);
            if (dresp.data_ok) begin
                lat = k;
                got = dresp.data;
                break;
            end
            check_eq("data_idle", dresp.data, 32'd0);
        end
        check_eq("data_ok_latency", 32'(lat), 32'(1 + LAT));
        check_eq("resp_data", got, exp_data);
        if (mis) begin
            err_m = 1'b1;
        end else if (st != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
            end
        end
        step();
        dreq.valid = 1'b0;
        #1;
        check_eq("data_ok_after", 32'(dresp.data_ok), 32'd0);
        check_eq("err_flag", 32'(err), 32'(err_m));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] old_word;
        logic [31:0] a;
        msize_t      s;
        logic [3:0]  st;

        dreq   = '0;
        dreq2  = '0;
        err_m  = 1'b0;
        resetn = 1'b0;
        dreq.valid  = 1'b1;
        dreq2.valid = 1'b1;
        step();
        step();
        check_eq("reset_addr_ok", 32'(dresp.addr_ok), 32'd0);
        check_eq("reset_data_ok", 32'(dresp.data_ok), 32'd0);
        check_eq("reset_data", dresp.data, 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_addr_ok_l0", 32'(dresp2.addr_ok), 32'd0);
        resetn      = 1'b1;
        dreq.valid  = 1'b0;
        dreq2.valid = 1'b0;
        #1;
        check_eq("idle_no_valid", 32'(dresp.addr_ok), 32'd0);

        // Full-word write then read back.
        txn(32'h10, MSIZE4, 4'hF, 32'hDEADBEEF, got);
        txn(32'h10, MSIZE4, 4'h0, 32'h0, got);
        check_eq("read_deadbeef", got, 32'hDEADBEEF);

        // Single byte lane update.
        txn(32'h10, MSIZE4, 4'b0010, 32'h0000AA00, got);
        txn(32'h10, MSIZE4, 4'h0, 32'h0, got);
        check_eq("read_lane1", got, 32'hDEADAAEF);

        // Address wraps modulo DEPTH*4.
        txn(DEPTH * 4 + 32'h8, MSIZE4, 4'hF, 32'h12345678, got);
        txn(32'h8, MSIZE4, 4'h0, 32'h0, got);
        check_eq("read_wrap", got, 32'h12345678);

        // Misaligned accesses: no write, zero data, sticky err.
        txn(32'h3, MSIZE4, 4'h0, 32'h0, got);
        check_eq("misaligned_data", got, 32'd0);
        txn(32'h12, MSIZE4, 4'hF, 32'hFFFFFFFF, got);
        txn(32'h11, MSIZE2, 4'hF, 32'hFFFFFFFF, got);
        txn(32'h10, MSIZE4, 4'h0, 32'h0, got);
        check_eq("misaligned_no_write", got, 32'hDEADAAEF);
        check_eq("err_sticky", 32'(err), 32'd1);
        txn(32'h12, MSIZE2, 4'b1100, 32'h55660000, got);
        txn(32'h13, MSIZE1, 4'b1000, 32'h77000000, got);
        txn(32'h10, MSIZE4, 4'h0, 32'h0, got);
        check_eq("aligned_sub_word", got, 32'h7766AAEF);

        // Randomised traffic over a 16-word window, high address bits random.
        for (int w = 0; w < 16; w++) txn(32'(w * 4), MSIZE4, 4'hF, $urandom, got);
        for (int n = 0; n < 200; n++) begin
            a  = $urandom & 32'hFFFF_F03F;
            s  = msize_t'($urandom_range(0, 2));
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            txn(a, s, st, $urandom, got);
        end

        // Reset during WAIT (k=1) and during RESP (k=1+LAT) aborts the write.
        for (int ab = 0; ab < 2; ab++) begin
            old_word = mem_m[8];
            dreq = '{valid: 1'b1, addr: 32'h20, size: MSIZE4, strobe: 4'hF, data: ~old_word};
            step();
            for (int k = 1; k < ((ab == 0) ? 1 : 1 + int'(LAT)); k++) step();
            resetn = 1'b0;
            #1;
            check_eq("abort_data_ok", 32'(dresp.data_ok), 32'd0);
            check_eq("abort_addr_ok", 32'(dresp.addr_ok), 32'd0);
            step();
            resetn     = 1'b1;
            dreq.valid = 1'b0;
            err_m      = 1'b0;
            #1;
            check_eq("abort_err_cleared", 32'(err), 32'd0);
            for (int k = 0; k < 4; k++) begin
                check_eq("abort_no_data_ok", 32'(dresp.data_ok), 32'd0);
                step();
            end
            txn(32'h20, MSIZE4, 4'h0, 32'h0, got);
            check_eq("abort_word_kept", got, old_word);
        end

        // LATENCY=0 instance: write, then hold valid for back-to-back reads.
        dreq2 = '{valid: 1'b1, addr: 32'h44, size: MSIZE4, strobe: 4'hF, data: 32'hCAFEF00D};
        #1;
        check_eq("l0_write_addr_ok", 32'(dresp2.addr_ok), 32'd1);
        step();
        dreq2 = '{valid: 1'b1, addr: 32'h4, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        #1;
        check_eq("l0_write_data_ok", 32'(dresp2.data_ok), 32'd1);
        check_eq("l0_write_addr_ok_resp", 32'(dresp2.addr_ok), 32'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            check_eq("l0_addr_ok", 32'(dresp2.addr_ok), (c % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("l0_data_ok", 32'(dresp2.data_ok), (c % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("l0_data", dresp2.data, (c % 2 == 1) ? 32'hCAFEF00D : 32'd0);
        end
        dreq2.valid = 1'b0;
        check_eq("l0_err", 32'(err2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_sram_resp.md
DBUS_SRAM_RESP -- requirements
Module: dbus_sram_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and data_ok (legal 0..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored (power of two).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port dreq  input  dbus_req_t  request from the core: valid, addr[31:0], size (msize_t: MSIZE1/2/4), strobe[3:0], data[31:0].
REQ-006 SHALL have port dresp  output  dbus_resp_t  response to the core: addr_ok, data_ok, data[31:0].
REQ-007 SHALL have port err  output  1  sticky flag for misaligned requests.

Function
REQ-008 SHALL implement states IDLE, WAIT, RESP; only one outstanding request at a time.
REQ-009 In IDLE, dresp.addr_ok SHALL equal dreq.valid (combinational); addr_ok SHALL be 0 in WAIT and RESP.
REQ-010 A request SHALL be accepted in a cycle with dreq.valid=1 and addr_ok=1; addr, size, strobe and data are latched in that cycle.
REQ-011 Changes on dreq after acceptance SHALL be ignored until the state returns to IDLE.
REQ-012 On acceptance, the next state SHALL be WAIT with a counter loaded to LATENCY; the next state SHALL be RESP directly if LATENCY=0.
REQ-013 In WAIT, the counter SHALL decrement each cycle; the state SHALL go to RESP in the cycle after the counter reaches 1.
REQ-014 Accepted at cycle T, dresp.data_ok SHALL be 1 for exactly one cycle, T+1+LATENCY, which is the RESP state.
REQ-015 RESP SHALL always return to IDLE the next cycle; a new request cannot be accepted in the RESP cycle.
REQ-016 Word index SHALL be addr[$clog2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-017 A request with latched strobe=0 is a read; in RESP, dresp.data SHALL be the full stored word at the index.
REQ-018 A request with strobe≠0 is a write; in the RESP cycle, each byte lane i with strobe[i]=1 SHALL be updated from data[8i+7:8i]; dresp.data SHALL be 0.
REQ-019 A request is misaligned if size=MSIZE2 with addr[0]=1, or size=MSIZE4 with addr[1:0]≠0.
REQ-020 A misaligned request SHALL still complete the handshake, perform no write, and return data 0.
REQ-021 A misaligned request SHALL set err to 1 in its RESP cycle; err is sticky.
REQ-022 A read in RESP SHALL observe all writes completed in earlier RESP cycles.
REQ-023 Outside RESP, dresp.data SHALL be 0 and dresp.data_ok SHALL be 0.

Reset
REQ-024 When resetn=0 at a clock edge, the state SHALL become IDLE, the counter 0, err 0, and the latched request fields 0.
REQ-025 During reset, addr_ok, data_ok and data SHALL be 0.
REQ-026 A reset in WAIT or RESP SHALL abort the request with no data_ok and no write.
REQ-027 Storage contents SHALL be unaffected by reset (not initialised).

Structure
REQ-028 dbus_req_t, dbus_resp_t and msize_t SHALL come from the shared common package; no local redefinition.
REQ-029 State enum and LATENCY counter width SHALL be local to the module.
REQ-030 The byte-strobed word array SHALL be one sub-module, sram_array: one read port, one strobed write port, same-cycle read sees old data.

Verification
REQ-031 Reset, write addr=0x10, size=MSIZE4, strobe=4'hF, data=0xDEADBEEF, then read 0x10 -> addr_ok in the accept cycle, data_ok at T+3, read data=0xDEADBEEF.
REQ-032 After REQ-031, write 0x10 with strobe=4'b0010, data=0x0000AA00, then read 0x10 -> data=0xDEADAAEF.
REQ-033 With LATENCY=0, hold valid continuously for back-to-back reads -> data_ok every other cycle, addr_ok only in IDLE cycles.
REQ-034 Read with addr=0x3, size=MSIZE4 -> handshake completes, data=0, err=1 and stays 1, memory unchanged.
REQ-035 Write addr=DEPTH*4+0x8, then read addr 0x8 -> same word (wrap-around).
REQ-036 Assert resetn=0 in WAIT during a write -> no data_ok, the word keeps its old value, state IDLE after reset.
